// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among NUM_REQ
// producers: captures one 16-bit word from the granted requester, issues a
// single tx_start pulse and follows tx_busy until the frame is finished.
// Optional busy-stuck watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = 2,
   parameter int BUSY_WAIT = 16,
   parameter int TIMEOUT   = 65535
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*16-1:0]  req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [ID_W-1:0]        grant_id,
   output logic [15:0]            tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   active,
   output logic                   timeout_err
);

   localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ID_W-1:0]     last_grant_q;
   logic [ID_W-1:0]     last_grant_d;
   logic [WAIT_W-1:0]   wait_cnt_q;
   logic [WAIT_W-1:0]   wait_cnt_d;
   logic [NUM_REQ-1:0]  ack_d;
   logic [ID_W-1:0]     grant_id_d;
   logic [15:0]         tx_data_d;
   logic                tx_start_d;
   logic                active_d;

   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [15:0]         win_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0]     to_cnt_q;
   logic [TO_W-1:0]     to_cnt_d;
   logic                timeout_err_d;
`else
   logic                unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT == 0);
   assign timeout_err        = 1'b0;
`endif

   // Round-robin search: the first set request after last_grant wins
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[i] &&
                (((32'(last_grant_q) + 32'(k)) % 32'(NUM_REQ)) == 32'(i))) begin
               win_found = 1'b1;
               win_id    = ID_W'(i);
            end
         end
      end
   end

   // Select the winner's word out of the flattened request data bus
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) begin
            win_data = req_data[16*i +: 16];
         end
      end
   end

   // Next-state and next-output logic for the grant/transmit sequence
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wait_cnt_d   = wait_cnt_q;
      ack_d        = '0;
      grant_id_d   = grant_id;
      tx_data_d    = tx_data;
      tx_start_d   = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_d      = to_cnt_q;
      timeout_err_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               ack_d      = NUM_REQ'(1) << win_id;
               grant_id_d = win_id;
               tx_data_d  = win_data;
               state_d    = START;
            end
         end
         START: begin
            tx_start_d = 1'b1;
            wait_cnt_d = '0;
            state_d    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
               to_cnt_d = '0;
`endif
               state_d  = WAIT_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               if (wait_cnt_d == WAIT_W'(BUSY_WAIT)) begin
                  last_grant_d = grant_id;
                  state_d      = IDLE;
               end
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               last_grant_d = grant_id;
               state_d      = IDLE;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_d == TO_W'(TIMEOUT)) begin
                  timeout_err_d = 1'b1;
                  last_grant_d  = grant_id;
                  state_d       = IDLE;
               end
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      active_d = (state_d != IDLE);
   end

   // State register and registered outputs; reset drops any word in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         wait_cnt_q   <= '0;
         ack          <= '0;
         grant_id     <= '0;
         tx_data      <= '0;
         tx_start     <= 1'b0;
         active       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
         ack          <= ack_d;
         grant_id     <= grant_id_d;
         tx_data      <= tx_data_d;
         tx_start     <= tx_start_d;
         active       <= active_d;
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   // Busy-stuck watchdog counter and its one-cycle error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q    <= '0;
         timeout_err <= 1'b0;
      end else begin
         to_cnt_q    <= to_cnt_d;
         timeout_err <= timeout_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Randomized self-checking bench for uart_tx_arbiter. A behavioural
// transmitter raises tx_busy 2 cycles after tx_start and holds it 40 cycles;
// grants are predicted by a round-robin scan over the request vector.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int ID_W        = 2;
   localparam int BUSY_WAIT   = 16;
   localparam int TIMEOUT     = 100;
   localparam int BUSY_DELAY  = 2;
   localparam int BUSY_HIGH   = 40;
   // cycles from the tx_start cycle to the first cycle with active low
   localparam int LEN_NORMAL  = BUSY_DELAY + BUSY_HIGH + 1;
   localparam int LEN_NO_BUSY = BUSY_WAIT;
   localparam int LEN_TIMEOUT = BUSY_DELAY + 1 + TIMEOUT;

   localparam int MODE_NORMAL = 0;
   localparam int MODE_NEVER  = 1;
   localparam int MODE_STUCK  = 2;

   logic                   clk;
   logic                   reset;
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ*16-1:0]  req_data;
   logic [NUM_REQ-1:0]     ack;
   logic [ID_W-1:0]        grant_id;
   logic [15:0]            tx_data;
   logic                   tx_start;
   logic                   tx_busy;
   logic                   active;
   logic                   timeout_err;

   int          error_count = 0;
   int          check_count = 0;
   int          last_model;
   int          last_wait;
   int          tx_mode;
   int          busy_dly;
   int          busy_hold;
   logic [15:0] words [NUM_REQ];

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ID_W      (ID_W),
      .BUSY_WAIT (BUSY_WAIT),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .grant_id    (grant_id),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .active      (active),
      .timeout_err (timeout_err)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural transmitter sharing the arbiter's reset
   initial begin
      tx_busy   = 1'b0;
      busy_dly  = 0;
      busy_hold = 0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            tx_busy   = 1'b0;
            busy_dly  = 0;
            busy_hold = 0;
         end else begin
            if (busy_hold > 0) begin
               busy_hold--;
               if (busy_hold == 0 && tx_mode != MODE_STUCK) tx_busy = 1'b0;
            end
            if (busy_dly > 0) begin
               busy_dly--;
               if (busy_dly == 0) begin
                  tx_busy   = 1'b1;
                  busy_hold = BUSY_HIGH;
               end
            end
            if (tx_start && tx_mode != MODE_NEVER) busy_dly = BUSY_DELAY;
         end
      end
   end

   // Hard time limit so a stuck design can never hang the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", error_count, check_count);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
      req = r;
      for (int i = 0; i < NUM_REQ; i++) req_data[16*i +: 16] = words[i];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int modelPick(input logic [NUM_REQ-1:0] r, input int last);
      int pick;
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (pick < 0 && r[(last + k) % NUM_REQ]) pick = (last + k) % NUM_REQ;
      end
      return pick;
   endfunction

   // after_req: 0 keep req, 1 drop req after ack, 2 scramble req/data in flight
   task automatic runFrame(input string tag, input int exp_len, input int exp_err,
                           input int after_req);
      int          winner;
      int          wait_n;
      int          len;
      int          starts;
      int          stray;
      int          errs;
      int          err_pos;
      int          data_bad;
      logic [15:0] exp_word;
      winner = modelPick(req, last_model);
      if (winner < 0) winner = 0;
      wait_n = 0;
      while (ack == '0 && wait_n < 100) begin
         tick();
         wait_n++;
      end
      last_wait = wait_n;
      exp_word  = words[winner];
      checkOutput({tag, "_ack"}, 32'(ack), 32'(1) << winner);
      checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'(winner));
      checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'(exp_word));
      checkOutput({tag, "_start_early"}, 32'(tx_start), 32'(0));
      if (after_req == 1) req = '0;
      tick();
      checkOutput({tag, "_tx_start"}, 32'(tx_start), 32'(1));
      checkOutput({tag, "_ack_once"}, 32'(ack), 32'(0));
      len      = 0;
      starts   = 0;
      stray    = 0;
      errs     = 0;
      err_pos  = -1;
      data_bad = 0;
      while (active && len < 400) begin
         if (after_req == 2) begin
            for (int i = 0; i < NUM_REQ; i++) words[i] = 16'($urandom);
            applyStimulus(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)));
         end
         tick();
         len++;
         if (tx_start) starts++;
         if (ack != '0) stray++;
         if (timeout_err) begin
            errs++;
            err_pos = len;
         end
         if (tx_data !== exp_word) data_bad++;
      end
      if (after_req == 2) req = '0;
      checkOutput({tag, "_active_len"}, 32'(len), 32'(exp_len));
      checkOutput({tag, "_extra_start"}, 32'(starts), 32'(0));
      checkOutput({tag, "_stray_ack"}, 32'(stray), 32'(0));
      checkOutput({tag, "_data_stable"}, 32'(data_bad), 32'(0));
      checkOutput({tag, "_timeout_err"}, 32'(errs), 32'(exp_err));
      if (exp_err > 0) checkOutput({tag, "_timeout_pos"}, 32'(err_pos), 32'(exp_len));
      last_model = winner;
   endtask

   // Directed scenarios followed by randomized frames
   initial begin
      int fair_seq [5];
      int wait_n;
      int errs;
      int inactive;
      int winner;
      fair_seq = '{0, 1, 2, 3, 0};
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      tx_mode  = MODE_NORMAL;
      for (int i = 0; i < NUM_REQ; i++) words[i] = 16'hA000 + 16'(i);
      applyStimulus(4'b1111);
      last_model = NUM_REQ - 1;

      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("rst_ack", 32'(ack), 32'(0));
         checkOutput("rst_tx_start", 32'(tx_start), 32'(0));
         checkOutput("rst_tx_data", 32'(tx_data), 32'(0));
         checkOutput("rst_grant_id", 32'(grant_id), 32'(0));
         checkOutput("rst_active", 32'(active), 32'(0));
         checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
      end
      reset = 1'b0;

      for (int f = 0; f < 5; f++) begin
         runFrame("fair", LEN_NORMAL, 0, 0);
         checkOutput("fair_order", 32'(grant_id), 32'(fair_seq[f]));
      end

      words[2] = 16'h3333;
      applyStimulus(4'b0100);
      runFrame("single", LEN_NORMAL, 0, 1);
      checkOutput("single_latency", 32'(last_wait), 32'(1));
      applyStimulus(4'b0000);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("idle_ack", 32'(ack), 32'(0));
         checkOutput("idle_active", 32'(active), 32'(0));
         checkOutput("idle_tx_data", 32'(tx_data), 32'h3333);
      end

      tx_mode = MODE_NEVER;
      for (int i = 0; i < NUM_REQ; i++) words[i] = 16'hB000 + 16'(i);
      applyStimulus(4'b1111);
      runFrame("nobusy", LEN_NO_BUSY, 0, 0);
      tx_mode = MODE_NORMAL;
      runFrame("after_nobusy", LEN_NORMAL, 0, 0);
      checkOutput("after_nobusy_grant", 32'(grant_id), 32'(0));

      applyStimulus(4'b0010);
      wait_n = 0;
      while (ack == '0 && wait_n < 100) begin
         tick();
         wait_n++;
      end
      checkOutput("mrst_ack", 32'(ack), 32'(4'b0010));
      req = '0;
      tick();
      checkOutput("mrst_tx_start", 32'(tx_start), 32'(1));
      repeat (12) tick();
      checkOutput("mrst_active_before", 32'(active), 32'(1));
      reset = 1'b1;
      applyStimulus(4'b1111);
      tick();
      checkOutput("mrst_active", 32'(active), 32'(0));
      checkOutput("mrst_tx_start_off", 32'(tx_start), 32'(0));
      checkOutput("mrst_no_ack", 32'(ack), 32'(0));
      checkOutput("mrst_tx_data", 32'(tx_data), 32'(0));
      reset      = 1'b0;
      last_model = NUM_REQ - 1;
      runFrame("post_rst", LEN_NORMAL, 0, 0);
      checkOutput("post_rst_grant", 32'(grant_id), 32'(0));

      tx_mode = MODE_STUCK;
      applyStimulus(4'b0100);
`ifdef UART_TX_ARB_TIMEOUT_EN
      runFrame("timeout", LEN_TIMEOUT, 1, 1);
      tx_mode   = MODE_NORMAL;
      tx_busy   = 1'b0;
      busy_hold = 0;
      busy_dly  = 0;
      applyStimulus(4'b1111);
      tick();
      checkOutput("timeout_single_pulse", 32'(timeout_err), 32'(0));
      runFrame("resume", LEN_NORMAL, 0, 0);
`else
      winner = modelPick(req, last_model);
      wait_n = 0;
      while (ack == '0 && wait_n < 100) begin
         tick();
         wait_n++;
      end
      checkOutput("stuck_ack", 32'(ack), 32'(1) << winner);
      req = '0;
      tick();
      checkOutput("stuck_tx_start", 32'(tx_start), 32'(1));
      errs     = 0;
      inactive = 0;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (timeout_err) errs++;
         if (!active) inactive++;
      end
      checkOutput("stuck_timeout_err", 32'(errs), 32'(0));
      checkOutput("stuck_inactive", 32'(inactive), 32'(0));
      tx_mode   = MODE_NORMAL;
      tx_busy   = 1'b0;
      busy_hold = 0;
      busy_dly  = 0;
      tick();
      checkOutput("stuck_release", 32'(active), 32'(0));
      last_model = winner;
      applyStimulus(4'b1111);
      runFrame("resume", LEN_NORMAL, 0, 0);
`endif

      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < NUM_REQ; i++) words[i] = 16'($urandom);
         applyStimulus(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)));
         runFrame("rand", LEN_NORMAL, 0, int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(4'b0000);
            tick();
            checkOutput("rand_idle_ack", 32'(ack), 32'(0));
            checkOutput("rand_idle_active", 32'(active), 32'(0));
         end
      end

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
